// File: rtl/muldiv_ctrl_pkg.sv
// Shared execute-stage ALU op codes used by the mul/div controller,
// plus a decode helper for the ops that start an iterative operation.
package muldiv_ctrl_pkg;

  localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  function automatic logic is_muldiv(input logic [7:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
           (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial
// subtract the divisor, keep the difference only if it did not go negative.
module div_step (
  input  logic [31:0] rem_i,
  input  logic        dvd_bit_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic        q_o
);

  logic [32:0] shifted;
  logic [32:0] diff;

  always_comb begin
    shifted = {rem_i, dvd_bit_i};
    diff    = shifted - {1'b0, divisor_i};
    // Partial remainder is below the divisor, so a borrow shows up in bit 32.
    q_o     = ~diff[32];
    rem_o   = q_o ? diff[31:0] : shifted[31:0];
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Execute-stage HI/LO multiply/divide controller: single-cycle 64-bit multiply,
// 32-cycle restoring divide, pipeline stall and a one-cycle done pulse.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [7:0]  alucontrol_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  import muldiv_ctrl_pkg::*;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  localparam int unsigned DivIters = 32;
  localparam logic [4:0]  LastIter = 5'(DivIters - 1);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        start;
  logic        div_signed;
  logic [31:0] a_mag, b_mag;
  logic [31:0] step_rem, quo_next, quo_fix, rem_fix;
  logic        step_q;
  logic [63:0] prod_s, prod_u, prod;

  assign start = (state_q == StIdle) && valid_i && !flush_i && is_muldiv(alucontrol_i);

  assign div_signed = (op_q == EXE_DIV_OP);
  assign a_mag = (div_signed && a_q[31]) ? -a_q : a_q;
  assign b_mag = (div_signed && b_q[31]) ? -b_q : b_q;

  div_step u_div_step (
    .rem_i    (rem_q),
    .dvd_bit_i(a_mag[LastIter - cnt_q]),
    .divisor_i(b_mag),
    .rem_o    (step_rem),
    .q_o      (step_q)
  );

  assign quo_next = {quo_q[30:0], step_q};
  assign quo_fix  = (div_signed && (a_q[31] ^ b_q[31])) ? -quo_next : quo_next;
  assign rem_fix  = (div_signed && a_q[31]) ? -step_rem : step_rem;

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};
  assign prod   = (op_q == EXE_MULT_OP) ? prod_s : prod_u;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    stall_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          stall_o = 1'b1;
          op_d    = alucontrol_i;
          a_d     = a_i;
          b_d     = b_i;
          cnt_d   = 5'd0;
          rem_d   = 32'd0;
          quo_d   = 32'd0;
          state_d = (alucontrol_i == EXE_MULT_OP || alucontrol_i == EXE_MULTU_OP) ?
                    StMul : StDiv;
        end
      end
      StMul: begin
        stall_o = 1'b1;
        hi_d    = prod[63:32];
        lo_d    = prod[31:0];
        state_d = StDone;
      end
      StDiv: begin
        stall_o = 1'b1;
        rem_d   = step_rem;
        quo_d   = quo_next;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == LastIter) begin
          state_d = StDone;
          // Divide by zero: remainder is the raw dividend, quotient all ones.
          if (b_q == 32'd0) begin
            hi_d = a_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (flush_i) begin
      state_d = StIdle;
      stall_o = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
    if (rst) stall_o = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      op_q    <= 8'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign done_o = (state_q == StDone) && !flush_i && !rst;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: expected HI/LO queued at issue and compared
// on the done pulse, with per-cycle stall/done/hold checks.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [7:0]  alucontrol_i;
  logic [31:0] a_i, b_i;
  logic        flush_i;
  logic        stall_o, done_o;
  logic [31:0] hi_o, lo_o;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  muldiv_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .alucontrol_i(alucontrol_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .flush_i     (flush_i),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      EXE_MULT_OP:  return 64'(sa * sb);
      EXE_MULTU_OP: return {32'b0, a} * {32'b0, b};
      EXE_DIV_OP: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      EXE_DIVU_OP: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Issue one op; instruction stays valid in EX through DONE, operands wander.
  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int   lat;
    exp_t e;
    lat = (op == EXE_DIV_OP || op == EXE_DIVU_OP) ? 33 : 2;
    sb.push_back('{hi: exp_hi, lo: exp_lo});
    valid_i      = 1'b1;
    alucontrol_i = op;
    a_i          = a;
    b_i          = b;
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      chk("stall", 64'(stall_o), 64'(c < lat));
      chk("done", 64'(done_o), 64'(c == lat));
      if (c == lat) begin
        e = sb.pop_front();
        chk("hi", 64'(hi_o), 64'(e.hi));
        chk("lo", 64'(lo_o), 64'(e.lo));
        last_hi = e.hi;
        last_lo = e.lo;
      end else if (c % 8 == 0) begin
        chk("hold", {hi_o, lo_o}, {last_hi, last_lo});
      end
      next_cycle();
      a_i = $urandom;
      b_i = $urandom;
    end
    valid_i = 1'b0;
  endtask

  task automatic quiet(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk({tag, "_stall"}, 64'(stall_o), 64'd0);
      chk({tag, "_done"}, 64'(done_o), 64'd0);
      if (c % 8 == 0) chk({tag, "_hold"}, {hi_o, lo_o}, {last_hi, last_lo});
      next_cycle();
    end
  endtask

  // DIV 1000/3 abandoned at C10 by flush (use_rst=0) or reset (use_rst=1).
  task automatic abort_div(input bit use_rst);
    valid_i      = 1'b1;
    alucontrol_i = EXE_DIV_OP;
    a_i          = 32'd1000;
    b_i          = 32'd3;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) begin
        if (use_rst) rst = 1'b1;
        else flush_i = 1'b1;
      end
      @(negedge clk);
      chk(use_rst ? "rst_stall" : "flush_stall", 64'(stall_o), 64'(c < 10));
      chk(use_rst ? "rst_done" : "flush_done", 64'(done_o), 64'd0);
      next_cycle();
    end
    rst     = 1'b0;
    flush_i = 1'b0;
    valid_i = 1'b0;
    if (use_rst) begin
      last_hi = 32'd0;
      last_lo = 32'd0;
    end
    quiet(30, use_rst ? "after_rst" : "after_flush");
  endtask

  initial begin
    logic [63:0] m;
    logic [7:0]  ops[4];
    logic [7:0]  op;
    logic [31:0] ra, rb;
    ops[0] = EXE_MULT_OP;
    ops[1] = EXE_MULTU_OP;
    ops[2] = EXE_DIV_OP;
    ops[3] = EXE_DIVU_OP;

    // Reset with a start attempt pending: reset must win.
    rst          = 1'b1;
    flush_i      = 1'b0;
    valid_i      = 1'b1;
    alucontrol_i = EXE_DIV_OP;
    a_i          = 32'd5;
    b_i          = 32'd1;
    next_cycle();
    @(negedge clk);
    chk("rst_stall", 64'(stall_o), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    rst     = 1'b0;
    valid_i = 1'b0;
    next_cycle();
    quiet(2, "post_rst");

    run_op(EXE_MULT_OP, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op(EXE_MULTU_OP, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(EXE_DIVU_OP, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op(EXE_DIVU_OP, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
    run_op(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op(EXE_DIV_OP, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op(EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);

    for (int i = 0; i < 6; i++) begin
      op = ops[$urandom_range(0, 3)];
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      m  = model(op, ra, rb);
      run_op(op, ra, rb, m[63:32], m[31:0]);
    end

    // Non-mul/div op, and mul/div without valid: nothing happens.
    valid_i      = 1'b1;
    alucontrol_i = EXE_ADD_OP;
    quiet(3, "add");
    valid_i      = 1'b0;
    alucontrol_i = EXE_DIV_OP;
    quiet(3, "novalid");

    // Flush in the start cycle blocks the start.
    valid_i = 1'b1;
    flush_i = 1'b1;
    @(negedge clk);
    chk("c0flush_stall", 64'(stall_o), 64'd0);
    next_cycle();
    flush_i = 1'b0;
    valid_i = 1'b0;
    quiet(3, "c0flush");

    abort_div(1'b0);
    run_op(EXE_MULTU_OP, 32'd6, 32'd7, 32'd0, 32'd42);
    abort_div(1'b1);
    run_op(EXE_DIVU_OP, 32'd100, 32'd7, 32'd2, 32'd14);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
